// File: rtl/fp_from_int_if.sv
// Handshake bundle for fp_from_int: integer operand in, packed {sign, exp, mant} word out.
interface fp_from_int_if #(
  parameter int IW = 32,
  parameter int NX = 8,
  parameter int NM = 23
);
  logic              in_valid;
  logic              in_ready;
  logic [IW-1:0]     in_data;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic [NX+NM:0]    out_data;
  logic              out_inexact;
  logic              out_overflow;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_inexact, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_inexact, out_overflow
  );
endinterface

// File: rtl/fp_from_int.sv
// Iterative integer -> {sign, exp, mant} converter, round-to-nearest-even, one operation in flight.
// Optional FP_FROM_INT_FASTNORM_EN: single-cycle leading-zero normalisation instead of 1 bit/cycle.
module fp_from_int #(
  parameter int IW = 32,
  parameter int NX = 8,
  parameter int NM = 23
) (
  input  logic         clk,
  input  logic         rst,
  fp_from_int_if.slave bus
);

  localparam int LZW  = (IW > 2) ? $clog2(IW) : 1;
  localparam int EW   = NX + 2;
  localparam int XW   = IW + NM + 1;
  localparam int BIAS = (1 << (NX - 1)) - 1;
  localparam int EMAX = (1 << NX) - 1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    mag;
  logic [LZW-1:0]   lz;
  logic             sign;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [NX+NM:0]   out_data_q;
  logic             inexact_q;
  logic             ovf_q;

  logic             sgn_in;
  logic [IW-1:0]    abs_in;
  logic [XW-1:0]    ext;
  logic [NM-1:0]    mant_raw;
  logic             g_bit;
  logic             s_bit;
  logic             rnd_up;
  logic [NM:0]      mant_sum;
  logic [EW-1:0]    exp_sum;
  logic             ovf;

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_inexact  = inexact_q;
  assign bus.out_overflow = ovf_q;

  // Most-negative input negates to 2^(IW-1), which is still representable unsigned.
  assign sgn_in = bus.in_signed & bus.in_data[IW-1];
  assign abs_in = sgn_in ? (~bus.in_data + IW'(1)) : bus.in_data;

  // Bits below the leading one, zero-padded so mant/G/S always exist.
  always_comb begin
    ext      = {mag[IW-2:0], {(NM+2){1'b0}}};
    mant_raw = ext[XW-1 -: NM];
    g_bit    = ext[XW-1-NM];
    s_bit    = |ext[XW-2-NM:0];
    rnd_up   = g_bit & (s_bit | mant_raw[0]);
    mant_sum = {1'b0, mant_raw} + {{NM{1'b0}}, rnd_up};
    exp_sum  = EW'(BIAS) + EW'(IW - 1) - EW'(lz) + EW'(mant_sum[NM]);
    ovf      = (exp_sum >= EW'(EMAX));
  end

`ifdef FP_FROM_INT_FASTNORM_EN
  logic [LZW-1:0] lzc;
  logic           found;

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = IW - 1; i >= 0; i--) begin
      if (!found && mag[i]) begin
        found = 1'b1;
        lzc   = LZW'(IW - 1 - i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mag         <= '0;
      lz          <= '0;
      sign        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      inexact_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign       <= sgn_in;
            mag        <= abs_in;
            lz         <= '0;
            in_ready_q <= 1'b0;
            if (abs_in == '0) begin
              out_data_q  <= '0;
              inexact_q   <= 1'b0;
              ovf_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
`ifdef FP_FROM_INT_FASTNORM_EN
          mag   <= mag << lzc;
          lz    <= lzc;
          state <= ROUND;
`else
          if (mag[IW-1]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            lz  <= lz + LZW'(1);
          end
`endif
        end
        ROUND: begin
          if (ovf) begin
            out_data_q <= {sign, {NX{1'b1}}, {NM{1'b0}}};
          end else begin
            out_data_q <= {sign, exp_sum[NX-1:0], mant_sum[NM-1:0]};
          end
          inexact_q   <= g_bit | s_bit | ovf;
          ovf_q       <= ovf;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_from_int.sv
// Directed-vector bench for fp_from_int: binary32 instance plus an NX=5/NM=10 instance for overflow.
module tb_fp_from_int;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  fp_from_int_if #(.IW(32), .NX(8), .NM(23)) b32 ();
  fp_from_int_if #(.IW(32), .NX(5), .NM(10)) b16 ();

  fp_from_int #(.IW(32), .NX(8), .NM(23)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b32.slave)
  );

  fp_from_int #(.IW(32), .NX(5), .NM(10)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edges from the accept edge (counted as 1) until out_valid is seen.
  function automatic int exp_lat(input int lz, input bit zero);
    if (zero) return 1;
`ifdef FP_FROM_INT_FASTNORM_EN
    return 3;
`else
    return lz + 3;
`endif
  endfunction

  task automatic do_op(input string tag, input logic [31:0] d, input logic s, input int lz,
                       input logic [31:0] exp_res, input logic exp_inx, input logic exp_ovf);
    int edges;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(b32.in_ready), 64'd1);
    b32.in_valid  = 1'b1;
    b32.in_data   = d;
    b32.in_signed = s;
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    b32.in_data  = 32'h0;
    edges = 1;
    while (!b32.out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_lat"}, 64'(edges), 64'(exp_lat(lz, d == 32'h0)));
    check({tag, "_data"}, 64'(b32.out_data), 64'(exp_res));
    check({tag, "_inexact"}, 64'(b32.out_inexact), 64'(exp_inx));
    check({tag, "_ovf"}, 64'(b32.out_overflow), 64'(exp_ovf));
    check({tag, "_busy"}, 64'(b32.in_ready), 64'd0);
    b32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b32.out_ready = 1'b0;
    check({tag, "_released"}, 64'({b32.out_valid, b32.in_ready}), 64'b01);
  endtask

  initial begin
    int edges;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_signed = 1'b0; b32.out_ready = 1'b0;
    b16.in_valid = 1'b0; b16.in_data = '0; b16.in_signed = 1'b0; b16.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", 64'(b32.in_ready), 64'd1);
    check("rst_out_valid", 64'(b32.out_valid), 64'd0);
    check("rst_out_data", 64'(b32.out_data), 64'd0);
    check("rst_flags", 64'({b32.out_inexact, b32.out_overflow}), 64'd0);
    check("rst16_out_data", 64'(b16.out_data), 64'd0);

    do_op("one_u",     32'h0000_0001, 1'b0, 31, 32'h3F80_0000, 1'b0, 1'b0);
    do_op("m1_s",      32'hFFFF_FFFF, 1'b1, 31, 32'hBF80_0000, 1'b0, 1'b0);
    do_op("minneg_s",  32'h8000_0000, 1'b1, 0,  32'hCF00_0000, 1'b0, 1'b0);
    do_op("minneg_u",  32'h8000_0000, 1'b0, 0,  32'h4F00_0000, 1'b0, 1'b0);
    do_op("tie_down",  32'h0100_0001, 1'b0, 7,  32'h4B80_0000, 1'b1, 1'b0);
    do_op("tie_up",    32'h0100_0003, 1'b1, 7,  32'h4B80_0002, 1'b1, 1'b0);
    do_op("carry_exp", 32'h7FFF_FFFF, 1'b0, 1,  32'h4F00_0000, 1'b1, 1'b0);
    do_op("exact24",   32'h00FF_FFFF, 1'b0, 8,  32'h4B7F_FFFF, 1'b0, 1'b0);
    do_op("zero",      32'h0000_0000, 1'b1, 0,  32'h0000_0000, 1'b0, 1'b0);

    // Backpressure: hold result 5 cycles while stray in_valid pulses are presented.
    @(negedge clk);
    b32.in_valid = 1'b1; b32.in_data = 32'd5; b32.in_signed = 1'b0;
    @(posedge clk);
    #1 b32.in_valid = 1'b0;
    edges = 1;
    while (!b32.out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("bp_lat", 64'(edges), 64'(exp_lat(29, 1'b0)));
    for (int i = 0; i < 5; i++) begin
      b32.in_valid = i[0];
      b32.in_data  = 32'h1234_5678;
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", i),
            64'({b32.out_valid, b32.in_ready, b32.out_data}), {30'd0, 1'b1, 1'b0, 32'h40A0_0000});
    end
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    @(posedge clk);
    #1 b32.out_ready = 1'b0;
    check("bp_release", 64'({b32.out_valid, b32.in_ready}), 64'b01);
    do_op("after_bp", 32'd2, 1'b0, 30, 32'h4000_0000, 1'b0, 1'b0);

    // Reset in the middle of normalisation discards the operation.
    @(negedge clk);
    b32.in_valid = 1'b1; b32.in_data = 32'd1; b32.in_signed = 1'b0;
    @(posedge clk);
    #1 b32.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_state", 64'({b32.out_valid, b32.in_ready}), 64'b01);
    check("midrst_data", 64'(b32.out_data), 64'd0);
    do_op("three", 32'd3, 1'b0, 30, 32'h4040_0000, 1'b0, 1'b0);

    // Half-precision-like instance: 2^32-1 exceeds the exponent range.
    @(negedge clk);
    b16.in_valid = 1'b1; b16.in_data = 32'hFFFF_FFFF; b16.in_signed = 1'b0;
    @(posedge clk);
    #1 b16.in_valid = 1'b0;
    edges = 1;
    while (!b16.out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("h_lat", 64'(edges), 64'(exp_lat(0, 1'b0)));
    check("h_data", 64'(b16.out_data), 64'h7C00);
    check("h_flags", 64'({b16.out_inexact, b16.out_overflow}), 64'b11);
    b16.out_ready = 1'b1;
    @(posedge clk);
    #1 b16.out_ready = 1'b0;
    check("h_released", 64'({b16.out_valid, b16.in_ready}), 64'b01);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
